watch_set_ctrl: RTL
===================

// Module: watch_set_ctrl
// PURPOSE
// - Time-set controller that sequences the user setting of the hh:mm watch counters from two push buttons.
// - Builds the 12-bit initial-value word (hours/min-tens/min-units) and issues a one-cycle load strobe that feeds the watch cfg_i/dvalid_i load path.
// - Sits between the button inputs and the watch top on the 32.768 kHz crystal clock domain; idle unless the user is editing.
// PARAMETERS
// - HOLD_CYC     16384   cycles inc must be held before auto-repeat starts (0.5 s)
// - REPEAT_CYC   4096    cycles between auto-repeat increments (125 ms)
// - TIMEOUT_CYC  327680  cycles without any press before an edit is abandoned (10 s)
// - BLINK_CYC    8192    half-period of the edit-digit blink (250 ms)
// PORTS
// - clk_i        in   1   32.768 kHz crystal clock (same clock as the watch counters)
// - rst_i        in   1   synchronous, active-high reset
// - smode_i      in   1   safe mode; forces abort of any edit, suppresses load
// - btn_mode_i   in   1   mode button, synchronised and debounced upstream, level
// - btn_inc_i    in   1   increment button, synchronised and debounced upstream, level
// - cfg_o        out  12  [3:0] min units 0-9, [6:4] min tens 0-5, [11:7] hours 0-23
// - dvalid_o     out  1   one-cycle load strobe, cfg_o valid in that cycle
// - editing_o    out  1   high in any edit state
// - blank_o      out  4   per-digit blank mask {h_tens,h_units,m_tens,m_units}
// BEHAVIOUR
// - Reset: state IDLE, cfg_o=0, dvalid_o=0, editing_o=0, blank_o=0, all counters 0, edge registers 0.
// - Buttons: rising edge = level high now and low in previous cycle; one press = one event.
// - FSM: IDLE -> SET_HOUR -> SET_MTENS -> SET_MUNITS -> COMMIT -> IDLE, each arrow on a mode event.
// - COMMIT lasts exactly 1 cycle: dvalid_o=1, cfg_o holds edited value. Latency: mode edge in SET_MUNITS at cycle n -> dvalid_o at n+1.
// - Inc event in SET_HOUR: hours+1, 23 wraps to 0. SET_MTENS: 5 wraps to 0. SET_MUNITS: 9 wraps to 0. No carry between fields.
// - Inc ignored in IDLE and COMMIT.
// - Auto-repeat: inc held HOLD_CYC cycles after its edge -> one extra event, then one per REPEAT_CYC while held. Release clears the hold counter.
// - Simultaneous mode and inc edges: mode wins, inc dropped, repeat counter cleared.
// - Timeout counter clears on any button event or state change. Reaching TIMEOUT_CYC-1 in an edit state -> IDLE, no dvalid_o, cfg_o keeps edited value.
// - Entering SET_HOUR from IDLE does not clear cfg_o; the last committed or edited value is the start point.
// - smode_i=1: next state IDLE from any state, dvalid_o forced 0 (including COMMIT cycle), button events ignored.
// - blank_o: in SET_HOUR bits[3:2], SET_MTENS bit[1], SET_MUNITS bit[0] follow blink phase. Phase toggles every BLINK_CYC, resets to 0 (shown) on state entry and on each inc event. Otherwise 0.
// - Counter widths: ceil(log2(max param)); TIMEOUT_CYC default needs 19 bits. Counters saturate, never wrap.
// STRUCTURE
// - Shared include watch_defs: FSM state encodings; cfg field offsets/widths (MU 3:0, MT 6:4, HH 11:7); field limits 9/5/23.
// - Sub-module btn_repeat (one instance, inc button): edge detect plus hold/repeat counter, 1-cycle event out, clear input.
// - Mode-button edge detect, FSM, field incrementers, timeout and blink counters inline.
// TESTING (bench uses HOLD=8, REPEAT=4, TIMEOUT=64, BLINK=4)
// - Mode x3 from reset, inc x2 in SET_HOUR, x1 in SET_MTENS, x7 in SET_MUNITS, mode -> one dvalid_o pulse, cfg_o=0x117 (h=2,mt=1,mu=7).
// - Hours at 23 + inc -> 0; mtens at 5 + inc -> 0; munits at 9 + inc -> 0; other fields unchanged.
// - Hold inc 20 cycles in SET_MUNITS from 0 -> edge, repeats at +8, +12, +16 -> munits=4 at release.
// - Enter SET_HOUR, idle 64 cycles -> state IDLE, editing_o=0, dvalid_o never asserted.
// - Mode and inc edges same cycle in SET_HOUR -> state SET_MTENS, hours unchanged.
// - smode_i=1 in the cycle the FSM enters COMMIT -> dvalid_o stays 0, state IDLE; rst_i mid-edit -> all outputs 0 next cycle.

Source files
------------

// File: rtl/watch_set_ctrl_pkg.sv
// Shared definitions for the watch time-set controller: FSM encodings, cfg word layout, field limits.
// Field limits double as wrap points for the per-digit incrementers.
package watch_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SET_HOUR   = 3'd1,
    ST_SET_MTENS  = 3'd2,
    ST_SET_MUNITS = 3'd3,
    ST_COMMIT     = 3'd4
  } state_t;

  localparam int CFG_W  = 12;
  localparam int MU_LSB = 0;
  localparam int MU_W   = 4;
  localparam int MT_LSB = 4;
  localparam int MT_W   = 3;
  localparam int HH_LSB = 7;
  localparam int HH_W   = 5;

  localparam logic [4:0] MU_MAX = 5'd9;
  localparam logic [4:0] MT_MAX = 5'd5;
  localparam logic [4:0] HH_MAX = 5'd23;

  // Fields never carry into each other; each one just rolls over at its own limit.
  function automatic logic [4:0] inc_wrap(input logic [4:0] val, input logic [4:0] max);
    return (val >= max) ? 5'd0 : val + 5'd1;
  endfunction

endpackage

// File: rtl/watch_set_ctrl_btn_repeat.sv
// Button edge detector with hold-to-repeat: 1-cycle event on press, after HOLD_CYC held cycles, then every REPEAT_CYC.
// Event is combinational with the sampled level; i_clr suppresses the event and disarms repeat until the next press.
module watch_set_ctrl_btn_repeat #(
  parameter int HOLD_CYC   = 16384,
  parameter int REPEAT_CYC = 4096
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  input  logic i_clr,
  output logic o_evt
);

  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD   = CW'(HOLD_CYC);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYC - REPEAT_CYC + 1);

  logic          r_btn_q;
  logic [CW-1:0] r_cnt;
  logic          w_edge;
  logic          w_rep;

  assign w_edge = i_btn & ~r_btn_q;
  assign w_rep  = i_btn & (r_cnt == HOLD);
  assign o_evt  = (w_edge | w_rep) & ~i_clr;

  // r_cnt == 0 means disarmed; reloading below HOLD spaces later repeats REPEAT_CYC apart.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_btn_q <= i_btn;
      if (i_clr || !i_btn) begin
        r_cnt <= '0;
      end else if (w_edge) begin
        r_cnt <= CW'(1);
      end else if (w_rep) begin
        r_cnt <= RELOAD;
      end else if (r_cnt != '0 && r_cnt != HOLD) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-set controller: mode/inc buttons edit hh:mm digits, commit issues a 1-cycle dvalid_o with cfg_o.
// Mode edge in SET_MUNITS at cycle n gives dvalid_o at n+1; smode_i aborts editing and masks dvalid_o.
module watch_set_ctrl
  import watch_set_ctrl_pkg::*;
#(
  parameter int HOLD_CYC    = 16384,
  parameter int REPEAT_CYC  = 4096,
  parameter int TIMEOUT_CYC = 327680,
  parameter int BLINK_CYC   = 8192
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             smode_i,
  input  logic             btn_mode_i,
  input  logic             btn_inc_i,
  output logic [CFG_W-1:0] cfg_o,
  output logic             dvalid_o,
  output logic             editing_o,
  output logic [3:0]       blank_o
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BL_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CFG_W-1:0] r_cfg;
  logic             r_dvalid;
  logic             r_mode_q;
  logic [TO_W-1:0]  r_to;
  logic [BL_W-1:0]  r_blink;
  logic             r_phase;
  logic             w_mode_edge;
  logic             w_rep_clr;
  logic             w_rep_evt;
  logic             w_edit;
  logic             w_inc_evt;
  logic             w_btn_evt;
  logic             w_state_chg;

  assign w_mode_edge = btn_mode_i & ~r_mode_q & ~smode_i;
  assign w_rep_clr   = w_mode_edge | smode_i;
  assign w_edit      = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MTENS) ||
                       (r_state == ST_SET_MUNITS);
  assign w_inc_evt   = w_rep_evt & w_edit;
  assign w_btn_evt   = w_mode_edge | w_rep_evt;
  assign w_state_chg = (w_state_nxt != r_state);

  watch_set_ctrl_btn_repeat #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_inc_rep (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_btn (btn_inc_i),
    .i_clr (w_rep_clr),
    .o_evt (w_rep_evt)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (smode_i) begin
      w_state_nxt = ST_IDLE;
    end else if (w_mode_edge) begin
      case (r_state)
        ST_IDLE:       w_state_nxt = ST_SET_HOUR;
        ST_SET_HOUR:   w_state_nxt = ST_SET_MTENS;
        ST_SET_MTENS:  w_state_nxt = ST_SET_MUNITS;
        ST_SET_MUNITS: w_state_nxt = ST_COMMIT;
        default:       w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state == ST_COMMIT) begin
      w_state_nxt = ST_IDLE;
    end else if (w_edit && !w_btn_evt && r_to == TO_MAX) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cfg    <= '0;
      r_dvalid <= 1'b0;
      r_mode_q <= 1'b0;
      r_to     <= '0;
      r_blink  <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_mode_q <= btn_mode_i;
      r_state  <= w_state_nxt;
      r_dvalid <= (w_state_nxt == ST_COMMIT);

      if (w_inc_evt) begin
        case (r_state)
          ST_SET_HOUR:
            r_cfg[HH_LSB +: HH_W] <= HH_W'(inc_wrap(5'(r_cfg[HH_LSB +: HH_W]), HH_MAX));
          ST_SET_MTENS:
            r_cfg[MT_LSB +: MT_W] <= MT_W'(inc_wrap(5'(r_cfg[MT_LSB +: MT_W]), MT_MAX));
          ST_SET_MUNITS:
            r_cfg[MU_LSB +: MU_W] <= MU_W'(inc_wrap(5'(r_cfg[MU_LSB +: MU_W]), MU_MAX));
          default: ;
        endcase
      end

      if (w_state_chg || w_btn_evt || !w_edit) begin
        r_to <= '0;
      end else if (r_to != TO_MAX) begin
        r_to <= r_to + TO_W'(1);
      end

      // Each entry and each increment restart the blink with the digit visible.
      if (w_state_chg || w_inc_evt || !w_edit) begin
        r_blink <= '0;
        r_phase <= 1'b0;
      end else if (r_blink == BL_MAX) begin
        r_blink <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= r_blink + BL_W'(1);
      end
    end
  end

  assign cfg_o     = r_cfg;
  assign dvalid_o  = r_dvalid & ~smode_i;
  assign editing_o = w_edit;

  always_comb begin
    blank_o = 4'b0000;
    case (r_state)
      ST_SET_HOUR:   blank_o = {r_phase, r_phase, 2'b00};
      ST_SET_MTENS:  blank_o = {2'b00, r_phase, 1'b0};
      ST_SET_MUNITS: blank_o = {3'b000, r_phase};
      default:       blank_o = 4'b0000;
    endcase
  end

endmodule
